seg7_capture: RTL and testbench

Front-panel receive side for the lab seven-segment displays. The block samples the segment lines a–g and dp as a driver presents them, waits until the pattern has been stable for a set time, and decodes it back to a 4-bit hex code. It reports each new character once, flags patterns that are not hex, and keeps a count of decoded characters. It sits between the board-level segment nets and any checker or logger that needs the displayed value in binary.

---
 rtl/seg7_capture.sv | 153 +++++++++++++++
 tb/tb_seg7_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_capture.sv
// Seven-segment receive side: synchronizes a-g/dp, qualifies a stable pattern,
// decodes it to hex and reports each newly accepted character once.
module seg7_capture #(
   parameter int STABLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       a,
   input  logic       b,
   input  logic       c,
   input  logic       d,
   input  logic       e,
   input  logic       f,
   input  logic       g,
   input  logic       dp,
   output logic [3:0] code,
   output logic       dp_out,
   output logic       valid,
   output logic       err,
   output logic       blank,
   output logic [7:0] char_count
);

   // state | meaning
   // HOLD  | current pattern accepted (or reset), waiting for it to change
   // COUNT | candidate pattern is being qualified for stability
   typedef enum logic {ST_HOLD = 1'b0, ST_COUNT = 1'b1} state_t;

   localparam logic [7:0] LP_LAST = 8'(STABLE_CYCLES - 1);

   logic [7:0] r_sync1;
   logic [7:0] r_sync2;
   logic [7:0] r_p;
   logic [7:0] r_cnt;
   state_t     r_state;
   state_t     w_state_nxt;

   logic [7:0] w_s;
   logic       w_change;
   logic       w_accept;
   logic       w_hit;
   logic [3:0] w_val;

   logic [3:0] r_code;
   logic       r_dp_out;
   logic       r_valid;
   logic       r_err;
   logic       r_blank;
   logic [7:0] r_char_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= {dp, g, f, e, d, c, b, a};
         r_sync2 <= r_sync1;
      end
   end

   assign w_s      = r_sync2;
   assign w_change = (w_s != r_p);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_HOLD;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_change)
         w_state_nxt = ST_COUNT;
      else if (r_state == ST_COUNT && r_cnt == LP_LAST)
         w_state_nxt = ST_HOLD;
   end

   always_comb begin
      w_accept = (r_state == ST_COUNT) && !w_change && (r_cnt == LP_LAST);
   end

   always_comb begin
      w_hit = 1'b1;
      w_val = 4'h0;
      unique case (r_p[6:0])
         7'h3F: w_val = 4'h0;
         7'h06: w_val = 4'h1;
         7'h5B: w_val = 4'h2;
         7'h4F: w_val = 4'h3;
         7'h66: w_val = 4'h4;
         7'h6D: w_val = 4'h5;
         7'h7D: w_val = 4'h6;
         7'h07: w_val = 4'h7;
         7'h7F: w_val = 4'h8;
         7'h6F: w_val = 4'h9;
         7'h77: w_val = 4'hA;
         7'h7C: w_val = 4'hB;
         7'h39: w_val = 4'hC;
         7'h5E: w_val = 4'hD;
         7'h79: w_val = 4'hE;
         7'h71: w_val = 4'hF;
         default: w_hit = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_p   <= '0;
         r_cnt <= '0;
      end else if (w_change) begin
         r_p   <= w_s;
         r_cnt <= 8'd1;
      end else if (r_state == ST_COUNT && r_cnt != LP_LAST) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Pulses default low every cycle; only an acceptance edge raises them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_code       <= 4'h0;
         r_dp_out     <= 1'b0;
         r_valid      <= 1'b0;
         r_err        <= 1'b0;
         r_blank      <= 1'b1;
         r_char_count <= 8'd0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         if (w_accept) begin
            r_dp_out <= r_p[7];
            if (r_p[6:0] == 7'h00) begin
               r_blank <= 1'b1;
            end else if (w_hit) begin
               r_code       <= w_val;
               r_valid      <= 1'b1;
               r_blank      <= 1'b0;
               r_char_count <= r_char_count + 8'd1;
            end else begin
               r_err   <= 1'b1;
               r_blank <= 1'b0;
            end
         end
      end
   end

   assign code       = r_code;
   assign dp_out     = r_dp_out;
   assign valid      = r_valid;
   assign err        = r_err;
   assign blank      = r_blank;
   assign char_count = r_char_count;

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a run-length model of the pin samples
// predicts each report; a monitor pops and compares whenever valid/err fires.
module tb_seg7_capture;
   localparam int S = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] pins = 8'h00;
   logic [3:0] code;
   logic       dp_out, valid, err, blank;
   logic [7:0] char_count;

   seg7_capture #(.STABLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .a(pins[0]), .b(pins[1]), .c(pins[2]), .d(pins[3]),
      .e(pins[4]), .f(pins[5]), .g(pins[6]), .dp(pins[7]),
      .code(code), .dp_out(dp_out), .valid(valid), .err(err),
      .blank(blank), .char_count(char_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         is_err;
      logic [3:0] code;
      bit         dp;
      logic [7:0] cnt;
      int         when;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad = 0;
   int edge_cnt = 0;

   logic [6:0] seg_tab[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [7:0] m_prev;
   int         m_run;
   logic [3:0] m_code;
   bit         m_dp;
   bit         m_blank;
   logic [7:0] m_cnt;

   function automatic int lookup(input logic [6:0] seg);
      for (int i = 0; i < 16; i++)
         if (seg_tab[i] == seg) return i;
      return -1;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (edge %0d)", nm, act, exp, edge_cnt);
      end
   endtask

   task automatic model_reset();
      m_prev  = 8'h00;
      m_run   = S;
      m_code  = 4'h0;
      m_dp    = 1'b0;
      m_blank = 1'b1;
      m_cnt   = 8'd0;
      q.delete();
   endtask

   // Reference: a pin value sampled S edges in a row is accepted, and is
   // reported two edges later (synchronizer delay).
   initial begin
      model_reset();
      forever begin
         @(posedge clk);
         edge_cnt++;
         if (rst_n) begin
            logic [7:0] v;
            v = pins;
            if (v != m_prev) begin
               m_prev = v;
               m_run  = 1;
            end else if (m_run < S) begin
               m_run++;
               if (m_run == S) begin
                  int idx;
                  exp_t x;
                  m_dp = v[7];
                  idx = lookup(v[6:0]);
                  if (v[6:0] == 7'h00) begin
                     m_blank = 1'b1;
                  end else if (idx >= 0) begin
                     m_code  = 4'(idx);
                     m_cnt   = m_cnt + 8'd1;
                     m_blank = 1'b0;
                     x = '{1'b0, m_code, m_dp, m_cnt, edge_cnt + 2};
                     q.push_back(x);
                  end else begin
                     m_blank = 1'b0;
                     x = '{1'b1, m_code, m_dp, m_cnt, edge_cnt + 2};
                     q.push_back(x);
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (valid || err) begin
            check("excl", {31'd0, valid & err}, 32'd0);
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected: valid=%0b err=%0b code=%0h at edge %0d", valid, err, code, edge_cnt);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("kind_err", {31'd0, err}, {31'd0, e.is_err});
               check("when", edge_cnt, e.when);
               check("code", {28'd0, code}, {28'd0, e.code});
               check("dp_out", {31'd0, dp_out}, {31'd0, e.dp});
               check("char_count", {24'd0, char_count}, {24'd0, e.cnt});
               check("blank_on_pulse", {31'd0, blank}, 32'd0);
            end
         end else if (q.size() > 0 && q[0].when < edge_cnt) begin
            total++;
            bad++;
            $display("FAIL missing: no pulse by edge %0d, want err=%0b code=%0h", q[0].when, q[0].is_err, q[0].code);
            void'(q.pop_front());
         end
      end
   end

   task automatic hold(input logic [7:0] pat, input int n);
      pins = pat;
      repeat (n) @(negedge clk);
   endtask

   task automatic settle_check(input string nm);
      repeat (S + 4) @(negedge clk);
      check({nm, "_code"}, {28'd0, code}, {28'd0, m_code});
      check({nm, "_dp"}, {31'd0, dp_out}, {31'd0, m_dp});
      check({nm, "_blank"}, {31'd0, blank}, {31'd0, m_blank});
      check({nm, "_cnt"}, {24'd0, char_count}, {24'd0, m_cnt});
      check({nm, "_pending"}, q.size(), 32'd0);
   endtask

   task automatic check_reset_vals(input string nm);
      check({nm, "_code"}, {28'd0, code}, 32'h0);
      check({nm, "_dp"}, {31'd0, dp_out}, 32'h0);
      check({nm, "_valid"}, {31'd0, valid}, 32'h0);
      check({nm, "_err"}, {31'd0, err}, 32'h0);
      check({nm, "_blank"}, {31'd0, blank}, 32'h1);
      check({nm, "_cnt"}, {24'd0, char_count}, 32'h0);
   endtask

   task automatic do_reset();
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_vals("rst_mid");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      pins  = 8'h00;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("rst");
      rst_n = 1'b1;
      hold(8'h00, 10);
      settle_check("idle");

      hold(8'h77, 20);
      settle_check("A");

      for (int i = 0; i < 16; i++) hold({1'b0, seg_tab[i]}, 10);
      settle_check("hex16");

      hold(8'h7F, 10);
      hold(8'hFF, 10);
      settle_check("dp8");

      hold(8'h71, 10);
      hold(8'h08, 2);
      hold(8'h71, 10);
      hold(8'h49, 10);
      settle_check("glitch_err");

      hold(8'h00, 10);
      hold(8'h06, 3);
      hold(8'h00, 10);
      settle_check("short");

      hold(8'h06, 3);
      do_reset();
      hold(8'h06, 10);
      settle_check("post_rst");

      pins = 8'h00;
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 256; i++) hold((i % 2 == 0) ? 8'h06 : 8'h5B, 6);
      settle_check("wrap");
      check("wrap_zero", {24'd0, char_count}, 32'd0);

      for (int i = 0; i < 300; i++) begin
         int r;
         logic [7:0] p;
         r = $urandom_range(0, 9);
         if (r < 6)       p = {1'b0, seg_tab[$urandom_range(0, 15)]};
         else if (r < 8)  p = {1'b0, 7'($urandom)};
         else             p = 8'h00;
         p[7] = 1'($urandom);
         hold(p, $urandom_range(1, 9));
      end
      settle_check("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end
endmodule
